// File: rtl/hex_word_tx.sv
// hex_word_tx: formats one parallel word as ASCII hex text ("0x", digits
// MSB first, CR LF) and streams it byte by byte into a UART transmitter's
// valid/ready byte interface. Each accepted byte is followed by GAP idle
// cycles with the data held, so a registered FIFO write downstream sees
// stable data.
module hex_word_tx #(
    parameter int WORD_BITS = 32,
    parameter int PREFIX    = 1,
    parameter int NEWLINE   = 1,
    parameter int GAP       = 2
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [WORD_BITS-1:0] i_word,
    output logic                 o_ready,
    output logic                 o_tx_valid,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_ready,
    output logic                 o_busy
);

    localparam int DIGITS = WORD_BITS / 4;
    localparam int N      = 2*PREFIX + DIGITS + 2*NEWLINE;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W  = $clog2(GAP + 1);

    localparam logic [IDX_W-1:0] LAST   = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP);

    typedef enum logic [1:0] {IDLE, EMIT, HOLD} state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [WORD_BITS-1:0] word_q, word_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 vld_n;
    logic [7:0]           dat_n;

    // Byte k of the line for word w: optional "0x", hex digits, optional CR LF.
    function automatic logic [7:0] byte_at(input logic [WORD_BITS-1:0] w, input int k);
        logic [3:0] nib;
        logic [7:0] b;
        int         d;
        d   = k - 2*PREFIX;
        nib = 4'h0;
        b   = 8'h00;
        if (PREFIX != 0 && k == 0) begin
            b = 8'h30;
        end else if (PREFIX != 0 && k == 1) begin
            b = 8'h78;
        end else if (d < DIGITS) begin
            nib = 4'(w >> (4*(DIGITS - 1 - d)));
            // 0..9 -> '0'..'9', 10..15 -> 'A'..'F' (0x41 - 10 = 0x37)
            b = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (d == DIGITS) begin
            b = 8'h0D;
        end else begin
            b = 8'h0A;
        end
        return b;
    endfunction

    // State, word, index, gap counter and registered byte outputs.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            word_q     <= '0;
            cnt        <= '0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            word_q     <= word_n;
            cnt        <= cnt_n;
            o_tx_valid <= vld_n;
            o_tx_data  <= dat_n;
        end
    end

    // Next-state logic; byte data is computed one step ahead so the
    // registered output lines up with the EMIT state.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        word_n  = word_q;
        cnt_n   = cnt;
        vld_n   = o_tx_valid;
        dat_n   = o_tx_data;
        unique case (state)
            IDLE: begin
                if (i_valid) begin
                    word_n  = i_word;
                    idx_n   = '0;
                    state_n = EMIT;
                    vld_n   = 1'b1;
                    dat_n   = byte_at(i_word, 0);
                end
            end
            EMIT: begin
                if (i_tx_ready) begin
                    state_n = HOLD;
                    cnt_n   = GAP_LD;
                    vld_n   = 1'b0;
                end
            end
            HOLD: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (idx == LAST) begin
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = EMIT;
                        vld_n   = 1'b1;
                        dat_n   = byte_at(word_q, int'(idx) + 1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);
    assign o_busy  = !o_ready;

endmodule

// File: tb/tb_hex_word_tx.sv
// Bench for hex_word_tx: a queue-based line model checked every cycle,
// directed cases with literal byte expectations, backpressure, async reset,
// random words with random transmitter ready, and two small configurations.
module tb_hex_word_tx;

    localparam int GAP = 2;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_word = '0;
    logic        i_tx_ready = 1'b1;
    logic        o_ready, o_tx_valid, o_busy;
    logic [7:0]  o_tx_data;

    logic        b_valid = 1'b0, b_tx_ready = 1'b1;
    logic [7:0]  b_word = '0;
    logic        b_ready, b_tx_valid, b_busy;
    logic [7:0]  b_tx_data;

    logic        c_valid = 1'b0, c_tx_ready = 1'b1;
    logic [3:0]  c_word = '0;
    logic        c_ready, c_tx_valid, c_busy;
    logic [7:0]  c_tx_data;

    int n_chk = 0;
    int n_pass = 0;

    bq_t log_a, log_b, log_c;

    // model state
    bit         m_busy = 0, m_vld = 0;
    logic [7:0] m_dat = 8'h00;
    int         m_gap = 0;
    bq_t        m_q;

    hex_word_tx dut (
        .clk(clk), .i_reset_n(rst_n), .i_valid(i_valid), .i_word(i_word),
        .o_ready(o_ready), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
        .i_tx_ready(i_tx_ready), .o_busy(o_busy)
    );

    hex_word_tx #(.WORD_BITS(8), .PREFIX(0), .NEWLINE(0), .GAP(2)) dut_b (
        .clk(clk), .i_reset_n(rst_n), .i_valid(b_valid), .i_word(b_word),
        .o_ready(b_ready), .o_tx_valid(b_tx_valid), .o_tx_data(b_tx_data),
        .i_tx_ready(b_tx_ready), .o_busy(b_busy)
    );

    hex_word_tx #(.WORD_BITS(4), .PREFIX(0), .NEWLINE(0), .GAP(2)) dut_c (
        .clk(clk), .i_reset_n(rst_n), .i_valid(c_valid), .i_word(c_word),
        .o_ready(c_ready), .o_tx_valid(c_tx_valid), .o_tx_data(c_tx_data),
        .i_tx_ready(c_tx_ready), .o_busy(c_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Text line for a 32-bit word with prefix and CR LF.
    function automatic bq_t fmt(input logic [31:0] w);
        bq_t q;
        int  n;
        q = {};
        q.push_back(8'h30);
        q.push_back(8'h78);
        for (int i = 7; i >= 0; i--) begin
            n = int'((w >> (4*i)) & 32'hF);
            q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    task automatic check_log(input string nm, input bq_t got, input bq_t exp);
        chk({nm, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), (i < got.size()) ? got[i] : 8'hxx, exp[i]);
    endtask

    // Line model: a queue of bytes still to send, one shown at a time,
    // then GAP silent cycles after each acceptance.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_vld = 0; m_dat = 8'h00; m_gap = 0; m_q = {};
        end else if (!m_busy) begin
            if (i_valid) begin
                m_q = fmt(i_word);
                m_busy = 1; m_vld = 1; m_dat = m_q[0];
            end
        end else if (m_vld) begin
            if (i_tx_ready) begin
                m_vld = 0; m_gap = GAP;
            end
        end else begin
            m_gap--;
            if (m_gap == 0) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_busy = 0;
                else begin m_vld = 1; m_dat = m_q[0]; end
            end
        end
    end

    // Per-cycle compare against the model, plus logs of accepted bytes.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("o_ready", o_ready, !m_busy);
            chk("o_busy", o_busy, m_busy);
            chk("o_tx_valid", o_tx_valid, m_vld);
            chk("o_tx_data", o_tx_data, m_dat);
            if (o_tx_valid && i_tx_ready) log_a.push_back(o_tx_data);
            if (b_tx_valid && b_tx_ready) log_b.push_back(b_tx_data);
            if (c_tx_valid && c_tx_ready) log_c.push_back(c_tx_data);
        end
    end

    task automatic start_word(input logic [31:0] w);
        i_valid = 1'b1;
        i_word  = w;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!o_ready) break;
        end
        chk("capture", o_ready, 1'b0);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic finish_word(output int busy_len);
        busy_len = 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (!o_busy) break;
            busy_len++;
        end
        chk("done", o_busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic run_word(input logic [31:0] w, output int busy_len);
        start_word(w);
        finish_word(busy_len);
    endtask

    initial begin
        int  bl, n;
        bit  done;
        bq_t e;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_valid", o_tx_valid, 1'b0);
        chk("rst_data", o_tx_data, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic line
        log_a = {};
        run_word(32'h1234ABCD, bl);
        e = '{8'h30, 8'h78, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        check_log("line1", log_a, e);
        chk("busy_len1", 64'(bl), 64'd36);

        // digit boundaries
        log_a = {};
        run_word(32'h09A0FFF0, bl);
        e = '{8'h30, 8'h78, 8'h30, 8'h39, 8'h41, 8'h30, 8'h46, 8'h46, 8'h46, 8'h30, 8'h0D, 8'h0A};
        check_log("line2", log_a, e);
        chk("busy_len2", 64'(bl), 64'd36);

        // extreme values
        log_a = {};
        run_word(32'h0, bl);
        check_log("zero", log_a, fmt(32'h0));
        log_a = {};
        run_word(32'hFFFFFFFF, bl);
        check_log("ones", log_a, fmt(32'hFFFFFFFF));

        // stall the 4th byte for 10 cycles
        log_a = {};
        fork
            run_word(32'h1234ABCD, bl);
            begin
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (log_a.size() >= 3) break;
                end
                @(posedge clk); #1;
                i_tx_ready = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    if (o_tx_valid) break;
                end
                n = 0;
                for (int k = 0; k < 10; k++) begin
                    chk("stall_valid", o_tx_valid, 1'b1);
                    chk("stall_data", o_tx_data, 8'h32);
                    n++;
                    if (k < 9) @(negedge clk);
                end
                @(posedge clk); #1;
                i_tx_ready = 1'b1;
            end
        join
        check_log("stall_line", log_a, fmt(32'h1234ABCD));
        chk("stall_busy_len", 64'(bl), 64'd46);

        // i_valid held across two words
        log_a = {};
        i_valid = 1'b1;
        i_word  = 32'hDEADBEEF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!o_ready) break;
        end
        @(posedge clk); #1;
        i_word = 32'h00000001;
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_ready) n++;
            else if (n > 0) break;
        end
        chk("ready_gap", 64'(n), 64'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        finish_word(bl);
        e = fmt(32'hDEADBEEF);
        e = {e, fmt(32'h00000001)};
        check_log("b2b", log_a, e);

        // asynchronous reset mid-digit
        start_word(32'h12345678);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (log_a.size() >= 4 + 24) break;
        end
        @(posedge clk); #1;
        i_tx_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_tx_valid) break;
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", o_tx_valid, 1'b0);
        chk("arst_data", o_tx_data, 8'h00);
        chk("arst_ready", o_ready, 1'b1);
        chk("arst_busy", o_busy, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        i_tx_ready = 1'b1;
        @(posedge clk); #1;
        log_a = {};
        run_word(32'hCAFEF00D, bl);
        e = '{8'h30, 8'h78, 8'h43, 8'h41, 8'h46, 8'h45, 8'h46, 8'h30, 8'h30, 8'h44, 8'h0D, 8'h0A};
        check_log("after_rst", log_a, e);

        // random words under random backpressure
        for (int r = 0; r < 15; r++) begin
            logic [31:0] w;
            w = $urandom;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            log_a = {};
            done = 0;
            fork
                begin run_word(w, bl); done = 1; end
                while (!done) begin
                    @(posedge clk); #1;
                    if (!done) i_tx_ready = ($urandom_range(0, 3) != 0);
                end
            join
            i_tx_ready = 1'b1;
            check_log($sformatf("rnd%0d", r), log_a, fmt(w));
        end

        // 8-bit, no prefix/newline
        log_b = {};
        b_valid = 1'b1;
        b_word  = 8'hF0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!b_ready) break;
        end
        @(posedge clk); #1;
        b_valid = 1'b0;
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!b_busy) break;
            n++;
        end
        e = '{8'h46, 8'h30};
        check_log("cfg8", log_b, e);
        chk("cfg8_busy", 64'(n), 64'd6);

        // single-byte line (N = 1)
        log_c = {};
        c_valid = 1'b1;
        c_word  = 4'hB;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!c_ready) break;
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        n = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!c_busy) break;
            n++;
        end
        e = '{8'h42};
        check_log("cfg4", log_c, e);
        chk("cfg4_busy", 64'(n), 64'd3);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
